// File: rtl/fir_pkg.sv
// Shared state type and accumulator sizing for the FIR MAC sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } fir_state_t;

  // Wide enough that LENGTH full-scale products can never wrap.
  function automatic int fir_acc_width(input int width, input int length);
    return 2 * width + $clog2(length);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate datapath with clear and enable.
// Define FIR_MAC_PIPE_EN to insert a product register ahead of the accumulator.
module fir_mac_unit #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 22
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [ACC_WIDTH-1:0] acc
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0]        a_ext_s;
  logic signed [PW-1:0]        b_ext_s;
  logic signed [PW-1:0]        prod_s;
  logic signed [PW-1:0]        addend_s;
  logic signed [ACC_WIDTH-1:0] acc_r;

  assign a_ext_s = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_ext_s = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s  = a_ext_s * b_ext_s;

`ifdef FIR_MAC_PIPE_EN
  logic signed [PW-1:0] prod_r;

  // Product register; cleared with the accumulator so the first MAC cycle adds zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_r <= '0;
    end else if (clr) begin
      prod_r <= '0;
    end else if (en) begin
      prod_r <= prod_s;
    end else begin
      prod_r <= prod_r;
    end
  end

  assign addend_s = prod_r;
`else
  assign addend_s = prod_s;
`endif

  // Accumulator: cleared before each result, holds while not enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + {{(ACC_WIDTH-PW){addend_s[PW-1]}}, addend_s};
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR sequencer: accepts a sample, shifts it into the delay line, then walks all taps through the MAC.
// Define FIR_MAC_PIPE_EN for a registered product (one extra MAC cycle).
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LENGTH     = 50,
  parameter int ADDR_WIDTH = $clog2(LENGTH),
  parameter int ACC_WIDTH  = fir_acc_width(WIDTH, LENGTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [WIDTH-1:0]     in_data,
  output logic                        shift_enb,
  output logic signed [WIDTH-1:0]     sample_out,
  output logic [ADDR_WIDTH-1:0]       tap_addr,
  input  logic signed [WIDTH-1:0]     tap_data,
  input  logic signed [WIDTH-1:0]     coef_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data
);

  localparam int CNT_W = $clog2(LENGTH + 1);
`ifdef FIR_MAC_PIPE_EN
  localparam logic [CNT_W-1:0] MAC_LAST = CNT_W'(LENGTH);
`else
  localparam logic [CNT_W-1:0] MAC_LAST = CNT_W'(LENGTH - 1);
`endif
  localparam logic [CNT_W-1:0] TAP_END = CNT_W'(LENGTH);

  fir_state_t                  state_r, state_nxt_s;
  logic [CNT_W-1:0]            cnt_r, cnt_nxt_s;
  logic [ADDR_WIDTH-1:0]       tap_addr_r, tap_addr_nxt_s;
  logic signed [WIDTH-1:0]     sample_r;
  logic                        in_ready_r, shift_enb_r, out_valid_r;
  logic signed [ACC_WIDTH-1:0] acc_s;

  // Next state and MAC cycle counter; the pipelined build runs one extra drain cycle.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = {CNT_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = SHIFT;
        else          state_nxt_s = IDLE;
      end
      SHIFT: state_nxt_s = MAC;
      MAC: begin
        if (cnt_r == MAC_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = MAC;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) state_nxt_s = IDLE;
        else                          state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
    if (cnt_nxt_s < TAP_END) tap_addr_nxt_s = ADDR_WIDTH'(cnt_nxt_s);
    else                     tap_addr_nxt_s = {ADDR_WIDTH{1'b0}};
  end

  // State and control outputs, decoded from the next state so every strobe is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      tap_addr_r  <= {ADDR_WIDTH{1'b0}};
      in_ready_r  <= 1'b1;
      shift_enb_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      tap_addr_r  <= tap_addr_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      shift_enb_r <= (state_nxt_s == SHIFT);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Sample capture on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_r <= '0;
    end else if ((state_r == IDLE) && in_valid) begin
      sample_r <= in_data;
    end else begin
      sample_r <= sample_r;
    end
  end

  fir_mac_unit #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (state_r == SHIFT),
    .en  (state_r == MAC),
    .a   (tap_data),
    .b   (coef_data),
    .acc (acc_s)
  );

  assign in_ready   = in_ready_r;
  assign shift_enb  = shift_enb_r;
  assign sample_out = sample_r;
  assign tap_addr   = tap_addr_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_valid_r ? acc_s : '0;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench: a 4-tap and a 50-tap sequencer, each with a bench-side delay line and coefficient store.
`timescale 1ns/1ps
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  localparam int W     = 8;
  localparam int L4    = 4;
  localparam int L50   = 50;
  localparam int AW4   = $clog2(L4);
  localparam int AW50  = $clog2(L50);
  localparam int ACW4  = fir_acc_width(W, L4);
  localparam int ACW50 = fir_acc_width(W, L50);
`ifdef FIR_MAC_PIPE_EN
  localparam int XLAT = 1;
`else
  localparam int XLAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic                     in_valid4, in_ready4, shift_enb4, out_valid4, out_ready4;
  logic signed [W-1:0]      in_data4, sample_out4, tap_data4, coef_data4;
  logic [AW4-1:0]           tap_addr4;
  logic signed [ACW4-1:0]   out_data4;
  logic signed [W-1:0]      dl4 [L4];
  logic signed [W-1:0]      coef4 [L4];

  logic                     in_valid50, in_ready50, shift_enb50, out_valid50, out_ready50;
  logic signed [W-1:0]      in_data50, sample_out50, tap_data50, coef_data50;
  logic [AW50-1:0]          tap_addr50;
  logic signed [ACW50-1:0]  out_data50;
  logic signed [W-1:0]      dl50 [L50];
  logic signed [W-1:0]      coef50 [L50];

  assign tap_data4   = dl4[tap_addr4];
  assign coef_data4  = coef4[tap_addr4];
  assign tap_data50  = dl50[tap_addr50];
  assign coef_data50 = coef50[tap_addr50];

  fir_mac_sequencer #(.WIDTH(W), .LENGTH(L4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .shift_enb(shift_enb4), .sample_out(sample_out4), .tap_addr(tap_addr4),
    .tap_data(tap_data4), .coef_data(coef_data4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4)
  );

  fir_mac_sequencer #(.WIDTH(W), .LENGTH(L50)) dut50 (
    .clk(clk), .rst(rst), .in_valid(in_valid50), .in_ready(in_ready50), .in_data(in_data50),
    .shift_enb(shift_enb50), .sample_out(sample_out50), .tap_addr(tap_addr50),
    .tap_data(tap_data50), .coef_data(coef_data50), .out_valid(out_valid50),
    .out_ready(out_ready50), .out_data(out_data50)
  );

  // Delay-line register files, cleared by the same reset as the sequencers.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < L4; i++) dl4[i] <= '0;
      for (int j = 0; j < L50; j++) dl50[j] <= '0;
    end else begin
      if (shift_enb4) begin
        dl4[0] <= sample_out4;
        for (int i = 1; i < L4; i++) dl4[i] <= dl4[i-1];
      end
      if (shift_enb50) begin
        dl50[0] <= sample_out50;
        for (int j = 1; j < L50; j++) dl50[j] <= dl50[j-1];
      end
    end
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one sample to the 4-tap instance, check latency and result, then the idle output.
  task automatic send4(input logic signed [W-1:0] d, input logic signed [63:0] exp, input string tag);
    int n;
    @(negedge clk);
    check({tag, "_ready"}, in_ready4, 1);
    in_valid4 = 1'b1;
    in_data4  = d;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_valid4 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, L4 + 1 + XLAT);
    check({tag, "_data"}, out_data4, exp);
    @(negedge clk);
    check({tag, "_idle_valid"}, out_valid4, 0);
    check({tag, "_idle_data"}, out_data4, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc_n, sh, res, cyc, seen;
    logic signed [63:0] last_out;
    rst = 1'b1;
    in_valid4 = 1'b0;  in_data4 = '0;  out_ready4 = 1'b1;
    in_valid50 = 1'b0; in_data50 = '0; out_ready50 = 1'b1;
    for (int i = 0; i < L4; i++) coef4[i] = 8'sd1;
    for (int j = 0; j < L50; j++) coef50[j] = -8'sd128;
    repeat (3) @(negedge clk);

    check("rst_in_ready", in_ready4, 1);
    check("rst_shift_enb", shift_enb4, 0);
    check("rst_sample_out", sample_out4, 0);
    check("rst_tap_addr", tap_addr4, 0);
    check("rst_out_valid", out_valid4, 0);
    check("rst_out_data", out_data4, 0);
    check("rst50_in_ready", in_ready50, 1);
    check("rst50_out_valid", out_valid50, 0);
    rst = 1'b0;

    // Unit coefficients: running sums of the samples.
    send4(8'sd1, 1, "s1");
    send4(8'sd2, 3, "s2");
    send4(8'sd3, 6, "s3");

    // Result held with out_ready low; extra in_valid must be ignored.
    out_ready4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b1;
    in_data4  = 8'sd4;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_valid4 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("hold_lat", n, L4 + 1 + XLAT);
    for (int k = 0; k < 10; k++) begin
      check("hold_data", out_data4, 10);
      check("hold_in_ready", in_ready4, 0);
      check("hold_shift", shift_enb4, 0);
      in_valid4 = 1'b1;
      in_data4  = -8'sd100;
      @(negedge clk);
    end
    in_valid4  = 1'b0;
    check("hold_still_valid", out_valid4, 1);
    out_ready4 = 1'b1;
    @(negedge clk);
    check("hold_released", out_valid4, 0);
    check("hold_back_idle", in_ready4, 1);
    send4(8'sd0, 9, "after_hold");

    // Mixed-sign coefficients.
    coef4[0] = 8'sd2; coef4[1] = -8'sd1; coef4[2] = 8'sd3; coef4[3] = -8'sd4;
    send4(-8'sd7, -14, "signed1");
    send4(8'sd127, 245, "signed2");

    // 50 back-to-back full-scale negative samples and coefficients.
    acc_n = 0; sh = 0; res = 0; cyc = 0; last_out = '0;
    in_valid50 = 1'b1;
    in_data50  = -8'sd128;
    while (res < 50 && cyc < 4000) begin
      if (in_valid50 && in_ready50) acc_n++;
      if (shift_enb50) sh++;
      if (out_valid50) begin
        res++;
        last_out = out_data50;
        check("b2b_data", out_data50, res * 16384);
      end
      @(negedge clk);
      cyc++;
      if (acc_n == 50) in_valid50 = 1'b0;
    end
    check("b2b_results", res, 50);
    check("b2b_shifts", sh, 50);
    check("b2b_accepts", acc_n, 50);
    check("b2b_full_scale", last_out, 819200);

    // Reset in the middle of MAC abandons the computation and clears the delay line.
    @(negedge clk);
    in_valid50 = 1'b1;
    in_data50  = 8'sd11;
    @(posedge clk);
    #1 in_valid50 = 1'b0;
    n = 0;
    while (tap_addr50 !== 6'd20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_reach20", (n < 200), 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready50, 1);
    check("mid_rst_shift", shift_enb50, 0);
    check("mid_rst_sample", sample_out50, 0);
    check("mid_rst_tap_addr", tap_addr50, 0);
    check("mid_rst_out_valid", out_valid50, 0);
    check("mid_rst_out_data", out_data50, 0);
    rst = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid50 !== 1'b0) seen = 1;
    end
    check("mid_rst_no_output", seen, 0);

    coef50[0] = 8'sd5;
    in_valid50 = 1'b1;
    in_data50  = 8'sd9;
    @(posedge clk);
    #1 in_valid50 = 1'b0;
    n = 0;
    @(negedge clk);
    while (out_valid50 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("post_rst_lat", n, L50 + 1 + XLAT);
    check("post_rst_data", out_data50, 45);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: sample and coefficient width, signed two's complement.
REQ-002 Parameter LENGTH, default 50: number of taps in the delay line; LENGTH >= 2.
REQ-003 Parameter ADDR_WIDTH, default $clog2(LENGTH): width of tap/coefficient address.
REQ-004 Parameter ACC_WIDTH, default 2*WIDTH+$clog2(LENGTH): accumulator and result width.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset: asynchronous, active-high.
REQ-007 in_valid  input  1  new input sample offered.
REQ-008 in_ready  output  1  sequencer accepts a sample this cycle.
REQ-009 in_data  input  WIDTH  signed input sample.
REQ-010 shift_enb  output  1  one-cycle shift strobe to the delay-line register file.
REQ-011 sample_out  output  WIDTH  signed sample written into delay-line cell 0 on shift.
REQ-012 tap_addr  output  ADDR_WIDTH  tap index driven to the delay line and the coefficient store.
REQ-013 tap_data  input  WIDTH  signed delay-line cell at tap_addr (combinational read, same cycle).
REQ-014 coef_data  input  WIDTH  signed coefficient at tap_addr (combinational read, same cycle).
REQ-015 out_valid  output  1  filter result available.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 out_data  output  ACC_WIDTH  signed filter result, sum over k of tap[k]*coef[k].

Function
REQ-018 FSM states SHALL be IDLE, SHIFT, MAC, DONE.
REQ-019 IDLE: in_ready=1; in_valid=1 latches in_data into a sample register -> SHIFT.
REQ-020 SHIFT: exactly one cycle; shift_enb=1, sample_out=latched sample, accumulator cleared to 0, tap_addr=0 -> MAC.
REQ-021 MAC: tap_addr steps 0,1,...,LENGTH-1, one per cycle; each cycle acc += sign-extended tap_data*coef_data.
REQ-022 MAC: after the product for address LENGTH-1 is accumulated -> DONE; tap_addr returns to 0.
REQ-023 DONE: out_valid=1, out_data=acc held stable until out_valid&&out_ready, then -> IDLE.
REQ-024 in_ready SHALL be 0 in SHIFT, MAC and DONE; in_valid in those states is ignored, not queued.
REQ-025 shift_enb SHALL be 0 in every state except SHIFT.
REQ-026 Latency without the option of REQ-031: input accepted at cycle T, out_valid first asserted at T+2+LENGTH.
REQ-027 Products SHALL be 2*WIDTH signed; accumulation SHALL be full ACC_WIDTH with no overflow for any input values, no saturation or rounding.
REQ-028 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-029 On rst: state=IDLE, in_ready=1, shift_enb=0, sample_out=0, tap_addr=0, out_valid=0, out_data=0, accumulator=0.
REQ-030 rst asserted mid-MAC or in DONE SHALL abandon the computation with no output; the delay line is cleared by the same rst.

Configuration
REQ-031 Macro FIR_MAC_PIPE_EN defined: one product register between multiplier and accumulator; MAC lasts LENGTH+1 cycles, latency T+3+LENGTH; product register cleared in SHIFT and on rst.
REQ-032 FIR_MAC_PIPE_EN undefined: product accumulated combinationally in the same cycle; MAC lasts LENGTH cycles, latency per REQ-026.

Structure
REQ-033 Shared package fir_pkg SHALL hold the state enum type and the ACC_WIDTH derivation constant/function.
REQ-034 Sub-module fir_mac_unit SHALL contain the multiplier, optional product register and accumulator with clear and enable inputs.

Verification
REQ-035 LENGTH=4, coefs all 1, samples 1,2,3 -> out_data 1,3,6; out_valid exactly at T+2+LENGTH each.
REQ-036 LENGTH=50, all taps and coefs -128 after 50 inputs -> out_data=819200, no wrap.
REQ-037 out_ready held 0 for 10 cycles in DONE -> out_data stable, in_ready=0, extra in_valid ignored.
REQ-038 rst pulsed at MAC address 20 -> next cycle all outputs at reset values; next sample result equals that sample*coef[0].
REQ-039 FIR_MAC_PIPE_EN defined, scenario REQ-035 -> identical values, latency T+3+LENGTH.
REQ-040 Back-to-back in_valid held high -> shift_enb exactly one pulse per accepted sample, one result per sample.
